float_multiplier_pipe: RTL
==========================

# float_multiplier_pipe

Three-stage pipelined floating-point multiplier that sits directly upstream of the floating-point accumulator. It takes operand pairs with a valid/ready handshake, produces packed sign/exponent/mantissa products, and presents each one with a single-cycle-qualified valid strobe that drives the accumulator's `Add` input. Together the two blocks form the MAC datapath. Special values are not supported: no infinities, NaNs or denormals.

## Interface
- `EXP_W`, default 8: exponent width.
- `MAN_W`, default 23: stored mantissa width; the hidden 1 is implicit.
- `DATA_W`, default 1+EXP_W+MAN_W: packed word width. The sign is bit DATA_W-1, the exponent is [DATA_W-2:MAN_W], the mantissa is [MAN_W-1:0]. Bias is 2^(EXP_W-1)-1.
- `Clk` input 1: the single clock, rising-edge.
- `Rst` input 1: asynchronous, active-low reset.
- `a` input DATA_W: operand A.
- `b` input DATA_W: operand B.
- `in_valid` input 1: the operand pair is valid.
- `in_ready` output 1: the block accepts the pair this cycle.
- `product` output DATA_W: result word, connected to the accumulator `addend`.
- `out_valid` output 1: `product` is valid; drives the accumulator `Add`.
- `out_ready` input 1: the consumer takes `product` this cycle. Tie it high for a free-running accumulator.

## Operation
- Transfer rules:
  - An input transfer occurs when `in_valid & in_ready`.
  - An output transfer occurs when `out_valid & out_ready`.
- Stage 1 (unpack):
  - Sign = a.sign XOR b.sign.
  - Exponent sum e = ea + eb - bias, held as a signed (EXP_W+2)-bit value.
  - Mantissas are registered with the hidden 1 prepended.
  - zero_flag is set if ea==0 or eb==0.
- Stage 2 (multiply): full (MAN_W+1)x(MAN_W+1) product p, 2*MAN_W+2 bits wide. Sign, e and zero_flag are carried alongside.
- Stage 3 (normalize and pack):
  - If p[2*MAN_W+1]=1: fraction = p[2*MAN_W:MAN_W+1] and e = e+1.
  - Otherwise: fraction = p[2*MAN_W-1:MAN_W].
  - Rounding is applied per the Configuration section.
- Result classification, in priority order:
  - zero_flag set, or final e <= 0: product = all zeros, including sign 0.
  - Final e >= 2^EXP_W-1: saturate to {sign, all-ones exponent, all-ones mantissa}.
  - Otherwise: {sign, e[EXP_W-1:0], fraction}.
- Flow control:
  - stall = out_valid & ~out_ready. While stalled, all three stages hold their contents.
  - in_ready = ~stall, computed combinationally.
  - When not stalled, every stage advances each cycle. Bubbles (valid=0) propagate normally; they do not collapse.
- Order is preserved. No operand pair is dropped or duplicated.

## Timing
- Reset (Rst=0, asynchronous):
  - All stage valid bits clear, so out_valid=0 and in_ready=1.
  - product = 0, and all pipeline data registers are 0.
- Latency: a pair accepted at edge N appears on `product`/`out_valid` after edge N+3, provided there are no stalls. Throughput is one pair per cycle.
- Every cycle of stall extends latency by exactly one cycle for every in-flight item.
- While out_valid=1 and out_ready=0, `product` is held stable.
- Reset asserted mid-operation discards all in-flight items. After release, the first output appears 3 cycles after the next accepted input.
- in_valid is ignored while in_ready=0. The source must hold a and b until the transfer completes.
- When out_ready=1, out_valid is high for exactly one cycle per product. This makes it safe to drive the accumulator `Add` directly.

## Configuration
- Macro: `FLOAT_MULT_ROUND_NEAREST_EN`.
- When defined, stage 3 rounds to nearest, ties to even:
  - The guard bit is the bit immediately below the fraction LSB. Sticky is the OR of all bits below the guard.
  - Increment when guard & (sticky | fraction LSB).
  - A carry out of the fraction sets fraction=0 and e=e+1. Overflow and underflow are checked after rounding.
- When not defined, the fraction is truncated, which matches the accumulator's truncation behaviour. No rounding logic is built.

## Test plan
- Basic product: a=0x3FC00000, b=0x40000000, one valid cycle. Required: product=0x40400000 with out_valid high 3 cycles after acceptance.
- Sign and zero:
  - 0xC0000000 x 0x40400000 gives 0xC0C00000.
  - 0x00000000 x 0x40490FDB gives 0x00000000.
- Overflow and underflow:
  - 0x7F000000 x 0x7F000000 gives 0x7FFFFFFF.
  - 0x00800000 x 0x00800000 gives 0x00000000.
- Rounding: 0x3FC00000 x 0x3F800001. Required: 0x3FC00001 with the macro undefined, 0x3FC00002 with `FLOAT_MULT_ROUND_NEAREST_EN` defined.
- Backpressure: stream 6 pairs back-to-back, with out_ready low for 5 cycles starting at the first out_valid. Required:
  - in_ready is low during the stall and product is held.
  - All 6 results emerge in order, with none lost and none duplicated.
- Reset mid-stream: pull Rst low with 2 items in flight. Required:
  - out_valid=0 and product=0 immediately.
  - After release, no stale output appears. A new pair produces its result after exactly 3 cycles.

Source files
------------

// File: rtl/float_multiplier_pipe.sv
// float_multiplier_pipe: pipelined floating-point multiplier feeding the
// accumulator's addend/Add inputs. No infinities, NaNs or denormals.
//
// Pipeline (each register level advances together unless the output is stalled):
//   stage 1 : unpack    - sign, biased exponent sum, mantissas with hidden 1
//   stage 2 : multiply  - (MAN_W+1)x(MAN_W+1) significand product
//   stage 3 : normalize - one-bit normalize shift, optional rounding
//   output  : classify  - zero / saturate / pack into product
// A pair accepted at edge N is presented after edge N+3.
//
// Ports:
//   Clk, Rst         clock (rising edge), asynchronous active-low reset
//   a, b             packed operands {sign, exponent, mantissa}
//   in_valid         operand pair valid
//   in_ready         pair accepted this cycle (combinational, ~stall)
//   product          packed result (registered)
//   out_valid        product valid (registered), drives accumulator Add
//   out_ready        consumer takes product this cycle
//
// Build option: define FLOAT_MULT_ROUND_NEAREST_EN for round-to-nearest-even;
// otherwise the fraction is truncated and no rounding logic exists.

module float_multiplier_pipe #(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned MAN_W  = 23,
  parameter int unsigned DATA_W = 1 + EXP_W + MAN_W
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] product,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int unsigned SE_W    = EXP_W + 2;
  localparam int unsigned SIG_W   = MAN_W + 1;
  localparam int unsigned PROD_W  = 2 * MAN_W + 2;
  localparam int unsigned BIAS    = (1 << (EXP_W - 1)) - 1;
  localparam int unsigned EXP_MAX = (1 << EXP_W) - 1;
`ifdef FLOAT_MULT_ROUND_NEAREST_EN
  // Rounding needs guard and sticky, so the whole product is kept.
  localparam int unsigned KEEP_LSB = 0;
`else
  // Truncation only looks at the top MAN_W+2 product bits.
  localparam int unsigned KEEP_LSB = MAN_W;
`endif
  localparam int unsigned KEEP_W  = PROD_W - KEEP_LSB;

  localparam logic signed [SE_W-1:0] EXP_ONE  = SE_W'(1);
  localparam logic signed [SE_W-1:0] EXP_ZERO = SE_W'(0);
  localparam logic signed [SE_W-1:0] EXP_BIAS = SE_W'(BIAS);
  localparam logic signed [SE_W-1:0] EXP_SAT  = SE_W'(EXP_MAX);

  logic advance;

  // Stage 1 registers
  logic                   s1Valid;
  logic                   s1Sign;
  logic signed [SE_W-1:0] s1Exp;
  logic [SIG_W-1:0]       s1ManA;
  logic [SIG_W-1:0]       s1ManB;
  logic                   s1Zero;

  // Stage 2 registers
  logic                   s2Valid;
  logic                   s2Sign;
  logic signed [SE_W-1:0] s2Exp;
  logic [KEEP_W-1:0]      s2Prod;
  logic                   s2Zero;

  // Stage 3 registers
  logic                   s3Valid;
  logic                   s3Sign;
  logic signed [SE_W-1:0] s3Exp;
  logic [MAN_W-1:0]       s3Frac;
  logic                   s3Zero;

  logic [EXP_W-1:0]       expA;
  logic [EXP_W-1:0]       expB;
  logic signed [SE_W-1:0] expSum;
  logic signed [SE_W-1:0] normExp;
  logic [MAN_W-1:0]       normFrac;
  logic signed [SE_W-1:0] finExp;
  logic [MAN_W-1:0]       finFrac;
  logic [DATA_W-1:0]      packWord;

  // The whole pipe freezes while the output word is offered but not taken.
  assign advance  = ~(out_valid & ~out_ready);
  assign in_ready = advance;

  assign expA   = a[DATA_W-2:MAN_W];
  assign expB   = b[DATA_W-2:MAN_W];
  assign expSum = $signed(SE_W'(expA)) + $signed(SE_W'(expB)) - EXP_BIAS;

  // Stage 1: unpack operands
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      s1Valid <= 1'b0;
      s1Sign  <= 1'b0;
      s1Exp   <= '0;
      s1ManA  <= '0;
      s1ManB  <= '0;
      s1Zero  <= 1'b0;
    end else if (advance) begin
      s1Valid <= in_valid;
      if (in_valid) begin
        s1Sign <= a[DATA_W-1] ^ b[DATA_W-1];
        s1Exp  <= expSum;
        s1ManA <= {1'b1, a[MAN_W-1:0]};
        s1ManB <= {1'b1, b[MAN_W-1:0]};
        s1Zero <= (expA == '0) | (expB == '0);
      end
    end
  end

  // Stage 2: significand multiply
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      s2Valid <= 1'b0;
      s2Sign  <= 1'b0;
      s2Exp   <= '0;
      s2Prod  <= '0;
      s2Zero  <= 1'b0;
    end else if (advance) begin
      s2Valid <= s1Valid;
      if (s1Valid) begin
        s2Sign <= s1Sign;
        s2Exp  <= s1Exp;
        s2Prod <= KEEP_W'((PROD_W'(s1ManA) * PROD_W'(s1ManB)) >> KEEP_LSB);
        s2Zero <= s1Zero;
      end
    end
  end

  // Normalize: product of two [1,2) significands lies in [1,4)
  always_comb begin
    normExp  = s2Exp;
    normFrac = s2Prod[2*MAN_W-1-KEEP_LSB -: MAN_W];
    if (s2Prod[KEEP_W-1]) begin
      normExp  = s2Exp + EXP_ONE;
      normFrac = s2Prod[2*MAN_W-KEEP_LSB -: MAN_W];
    end
  end

`ifdef FLOAT_MULT_ROUND_NEAREST_EN
  logic             guardBit;
  logic             stickyBit;
  logic             roundUp;
  logic             roundCarry;
  logic [MAN_W-1:0] roundFrac;

  // Round to nearest, ties to even; a fraction carry bumps the exponent.
  always_comb begin
    if (s2Prod[PROD_W-1]) begin
      guardBit  = s2Prod[MAN_W];
      stickyBit = |s2Prod[MAN_W-1:0];
    end else begin
      guardBit  = s2Prod[MAN_W-1];
      stickyBit = |s2Prod[MAN_W-2:0];
    end
    roundUp = guardBit & (stickyBit | normFrac[0]);
    {roundCarry, roundFrac} = {1'b0, normFrac} + (MAN_W+1)'(roundUp);
    finExp  = normExp;
    finFrac = roundFrac;
    if (roundCarry) begin
      finExp  = normExp + EXP_ONE;
      finFrac = '0;
    end
  end
`else
  // Truncate: the normalized fraction is used as is.
  always_comb begin
    finExp  = normExp;
    finFrac = normFrac;
  end
`endif

  // Stage 3: normalized (and rounded) result
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      s3Valid <= 1'b0;
      s3Sign  <= 1'b0;
      s3Exp   <= '0;
      s3Frac  <= '0;
      s3Zero  <= 1'b0;
    end else if (advance) begin
      s3Valid <= s2Valid;
      if (s2Valid) begin
        s3Sign <= s2Sign;
        s3Exp  <= finExp;
        s3Frac <= finFrac;
        s3Zero <= s2Zero;
      end
    end
  end

  // Classify: zero wins over saturation, zero result carries sign 0.
  always_comb begin
    packWord = '0;
    if (s3Zero || (s3Exp <= EXP_ZERO)) begin
      packWord = '0;
    end else if (s3Exp >= EXP_SAT) begin
      packWord = {s3Sign, {EXP_W{1'b1}}, {MAN_W{1'b1}}};
    end else begin
      packWord = {s3Sign, s3Exp[EXP_W-1:0], s3Frac};
    end
  end

  // Output register: product is only rewritten when a new result arrives.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      out_valid <= 1'b0;
      product   <= '0;
    end else if (advance) begin
      out_valid <= s3Valid;
      if (s3Valid) begin
        product <= packWord;
      end
    end
  end

endmodule
